// File: rtl/act_requant_packer_if.sv
//------------------------------------------------------------------------------
// Module   : act_requant_packer_if
// Purpose  : Packed-word valid/ready bus from the requant packer to the UB writer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface act_requant_packer_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;

  modport master (output out_valid, output out_data, output out_bytes, input out_ready);
  modport slave  (input out_valid, input out_data, input out_bytes, output out_ready);
endinterface

`default_nettype wire

// File: rtl/act_requant_packer.sv
//------------------------------------------------------------------------------
// Module   : act_requant_packer
// Purpose  : Requantize int32 activations to int8 (multiply, round-half-up
//            shift, saturate), pack 4 bytes per word, buffer in a FIFO.
//            Define ACT_REQUANT_SAT_COUNT_EN to enable the saturation counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module act_requant_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 valid_in,
  input  wire logic [31:0]          data_in,
  input  wire logic                 last_in,
  input  wire logic [15:0]          scale,
  input  wire logic [4:0]           shift,
  act_requant_packer_if.master      out,
  output logic                      overflow,
  output logic [15:0]               sat_count
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

  // ---------------- Stage 1: multiply ----------------
  logic signed [47:0] w_a;
  logic signed [47:0] w_b;
  logic signed [47:0] w_prod;

  assign w_a    = {{16{data_in[31]}}, data_in};
  assign w_b    = {32'b0, scale};
  assign w_prod = w_a * w_b;

  logic               r_s1_valid;
  logic               r_s1_last;
  logic signed [47:0] r_s1_prod;
  logic [4:0]         r_s1_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_prod  <= '0;
      r_s1_shift <= '0;
    end else begin
      r_s1_valid <= valid_in;
      r_s1_last  <= valid_in & last_in;
      r_s1_prod  <= w_prod;
      r_s1_shift <= shift;
    end
  end

  // ---------------- Stage 2: round, shift, saturate ----------------
  // One guard bit keeps the rounding add from wrapping at the product extreme.
  logic signed [48:0] w_ext;
  logic signed [48:0] w_half;
  logic signed [48:0] w_sum;
  logic signed [48:0] w_shr;
  logic signed [48:0] w_r;
  logic               w_sat_hi;
  logic               w_sat_lo;
  logic [7:0]         w_byte;

  assign w_ext    = {r_s1_prod[47], r_s1_prod};
  assign w_half   = 49'sd1 <<< (r_s1_shift - 5'd1);
  assign w_sum    = w_ext + w_half;
  assign w_shr    = w_sum >>> r_s1_shift;
  assign w_r      = (r_s1_shift == 5'd0) ? w_ext : w_shr;
  assign w_sat_hi = (w_r > 49'sd127);
  assign w_sat_lo = (w_r < -49'sd128);
  assign w_byte   = w_sat_hi ? 8'h7F : (w_sat_lo ? 8'h80 : w_r[7:0]);

  logic       r_s2_valid;
  logic       r_s2_last;
  logic [7:0] r_s2_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_byte  <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_valid & r_s1_last;
      r_s2_byte  <= w_byte;
    end
  end

`ifdef ACT_REQUANT_SAT_COUNT_EN
  logic        r_s2_sat;
  logic [15:0] r_sat_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_sat    <= 1'b0;
      r_sat_count <= '0;
    end else begin
      r_s2_sat <= r_s1_valid & (w_sat_hi | w_sat_lo);
      if (r_s2_valid && r_s2_sat && (r_sat_count != 16'hFFFF))
        r_sat_count <= r_sat_count + 16'd1;
    end
  end

  assign sat_count = r_sat_count;
`else
  assign sat_count = '0;
`endif

  // ---------------- Pack stage ----------------
  logic [1:0]  r_lane;
  logic [23:0] r_partial;
  logic [31:0] w_word;
  logic [2:0]  w_bytes;
  logic        w_push;

  assign w_word  = {8'b0, r_partial} | ({24'b0, r_s2_byte} << {r_lane, 3'b000});
  assign w_bytes = {1'b0, r_lane} + 3'd1;
  assign w_push  = r_s2_valid & ((r_lane == 2'd3) | r_s2_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lane    <= '0;
      r_partial <= '0;
    end else if (r_s2_valid) begin
      if (w_push) begin
        r_lane    <= '0;
        r_partial <= '0;
      end else begin
        r_lane    <= r_lane + 2'd1;
        r_partial <= w_word[23:0];
      end
    end
  end

  // ---------------- FIFO ----------------
  logic [34:0]   r_mem [FIFO_DEPTH];
  logic [c_AW:0] r_wr_ptr;
  logic [c_AW:0] r_rd_ptr;
  logic          r_overflow;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr_en;
  logic [34:0]   w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_pop   = ~w_empty & out.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr_en = w_push & (~w_full | w_pop);
  assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[r_wr_ptr[c_AW-1:0]] <= {w_bytes, w_word};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en)
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      if (w_push && w_full && !w_pop)
        r_overflow <= 1'b1;
    end
  end

  assign out.out_valid = ~w_empty;
  assign out.out_data  = w_empty ? 32'd0 : w_head[31:0];
  assign out.out_bytes = w_empty ? 3'd0  : w_head[34:32];
  assign overflow      = r_overflow;

endmodule

`default_nettype wire
